// File: rtl/imem_responder_pkg.sv
// Shared instruction-bus types and imem_responder definitions.
// Holds the FSM state enum, the default base address and the range/alignment fault helper.
package common;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_t;

    localparam logic [63:0] IMEM_BASE = 64'h8000_0000;

    // 'limit' is the first byte address past the end of the memory.
    function automatic logic imem_fault(input logic [63:0] addr,
                                        input logic [63:0] base,
                                        input logic [63:0] limit);
        return (addr[1:0] != 2'b00) || (addr < base) || (addr >= limit);
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Instruction-bus request/response pair between a fetch stage and a responder.
// The fetch stage uses the master modport; the memory side uses the slave modport.
interface imem_responder_if;
    import common::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;

    modport master (output ireq, input  iresp);
    modport slave  (input  ireq, output iresp);
endinterface

// File: rtl/imem_responder_linebuf.sv
// One-entry line buffer for imem_responder: it holds the last fetched 64-bit word with its index.
// A load-port write to the buffered index invalidates the entry in the same cycle.
module imem_linebuf #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] lookup_idx,
    input  logic          fill_en,
    input  logic [AW-1:0] fill_idx,
    input  logic [63:0]   fill_word,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    output logic          hit,
    output logic [63:0]   word
);

    logic          valid_q;
    logic [AW-1:0] tag_q;
    logic [63:0]   word_q;
    logic          inval;

    assign inval = ld_en && valid_q && (ld_addr == tag_q);
    assign hit   = valid_q && (tag_q == lookup_idx) && !inval;
    assign word  = word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            word_q  <= '0;
        end else if (fill_en) begin
            // A fill that collides with a load to the same index got the old word, so keep it invalid.
            valid_q <= !(ld_en && (ld_addr == fill_idx));
            tag_q   <= fill_idx;
            word_q  <= fill_word;
        end else if (inval) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: it answers ibus fetches from a preloadable 64-bit memory after LATENCY wait states.
// Defining IMEM_LINEBUF_EN adds a one-entry line buffer that answers repeat fetches one cycle after acceptance.
module imem_responder
    import common::*;
#(
    parameter  int unsigned DEPTH   = 4096,
    parameter  int unsigned LATENCY = 2,
    parameter  logic [63:0] BASE    = IMEM_BASE,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    imem_responder_if.slave  ibus,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [63:0]      ld_data,
    output logic             fault,
    output logic             busy
);

    localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    imem_state_t   state, state_next;
    logic [63:0]   addr_q;
    logic [3:0]    cnt_q;
    logic [31:0]   data_q;
    logic          fault_q;
    logic [63:0]   mem [DEPTH];

    logic          accept;
    logic          capture;
    logic          lb_hit;
    logic [63:0]   cap_addr;
    logic [AW-1:0] cap_idx;
    logic          cap_fault;
    logic [63:0]   cap_word;
    logic [31:0]   cap_data;

    function automatic logic [AW-1:0] word_idx(input logic [63:0] a);
        return AW'((a - BASE) >> 3);
    endfunction

    assign accept = (state == IDLE) && ibus.ireq.valid;

    // In IDLE the capture address comes from the live request; this covers a buffer hit or LATENCY == 0.
    assign cap_addr  = (state == IDLE) ? ibus.ireq.addr : addr_q;
    assign cap_idx   = word_idx(cap_addr);
    assign cap_fault = imem_fault(cap_addr, BASE, LIMIT);

`ifdef IMEM_LINEBUF_EN
    logic          lb_match;
    logic [63:0]   lb_word;
    logic [AW-1:0] req_idx;
    logic          req_fault;
    logic          lb_fill;

    assign req_idx   = word_idx(ibus.ireq.addr);
    assign req_fault = imem_fault(ibus.ireq.addr, BASE, LIMIT);
    assign lb_hit    = accept && lb_match && !req_fault;
    assign lb_fill   = capture && !lb_hit && !cap_fault;
    assign cap_word  = lb_hit ? lb_word : mem[cap_idx];

    imem_linebuf #(.AW(AW)) u_linebuf (
        .clk        (clk),
        .rst        (rst),
        .lookup_idx (req_idx),
        .fill_en    (lb_fill),
        .fill_idx   (cap_idx),
        .fill_word  (cap_word),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .hit        (lb_match),
        .word       (lb_word)
    );
`else
    assign lb_hit   = 1'b0;
    assign cap_word = mem[cap_idx];
`endif

    assign cap_data = cap_fault ? 32'h0 : (cap_addr[2] ? cap_word[63:32] : cap_word[31:0]);

    always_comb begin
        // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
        capture = 1'b0;
        unique case (state)
            IDLE:    capture = accept && (lb_hit || (LAT == 4'd0));
            WAIT:    capture = (cnt_q == 4'd1);
            default: capture = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (ibus.ireq.valid) state_next = capture ? RESP : WAIT;
            WAIT:    if (cnt_q == 4'd1)   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The response register is loaded only on entry to RESP and cleared on exit, so it reads 0 outside RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= ibus.ireq.addr;
                cnt_q  <= LAT;
            end else if (state == WAIT) begin
                cnt_q  <= cnt_q - 4'd1;
            end

            if (capture) begin
                data_q  <= cap_data;
                fault_q <= cap_fault;
            end else if (state == RESP) begin
                data_q  <= '0;
                fault_q <= 1'b0;
            end
        end
    end

    // NOTE: the memory array has no reset, so it maps onto RAM and its contents survive rst.
    // The capture reads the pre-edge word, so a same-cycle load is read-before-write.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    // Output decode.
    always_comb begin
        ibus.iresp         = '0;
        ibus.iresp.addr_ok = accept;
        ibus.iresp.data_ok = (state == RESP);
        ibus.iresp.data    = data_q;
        fault              = fault_q;
        busy               = (state != IDLE);
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: preload, fetch latency/data, faults, reset abort, load collision.
// Expected latencies follow IMEM_LINEBUF_EN when the bench is built with it.
module tb_imem_responder;
    import common::*;

    localparam int unsigned DEPTH   = 4096;
    localparam int unsigned LATENCY = 2;
    localparam int          AW      = 12;
    localparam int          MISS_LAT = LATENCY + 1;
`ifdef IMEM_LINEBUF_EN
    localparam int          HIT_LAT  = 1;
`else
    localparam int          HIT_LAT  = LATENCY + 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [63:0]   ld_data = '0;
    logic          fault;
    logic          busy;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    imem_responder_if bus();

    imem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .BASE    (64'h8000_0000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ibus    (bus.slave),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .fault   (fault),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic load(input logic [AW-1:0] idx, input logic [63:0] d);
        ld_en = 1'b1; ld_addr = idx; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // One fetch: checks acceptance, latency (cycles from accept to data_ok), data and fault.
    // ld_at > 0 pulses the load port during that cycle after acceptance.
    task automatic fetch(input string tag, input logic [63:0] a, input bit hold,
                         input int exp_lat, input logic [31:0] exp_data, input logic exp_fault,
                         input int ld_at, input logic [AW-1:0] la, input logic [63:0] ldd,
                         output int t_acc);
        int  n;
        bit  seen;
        bus.ireq.valid = 1'b1;
        bus.ireq.addr  = a;
        @(negedge clk);
        check({tag, ".addr_ok"}, 64'(bus.iresp.addr_ok), 64'd1);
        t_acc = cyc;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            ld_en = (n == ld_at); ld_addr = la; ld_data = ldd;
            @(negedge clk);
            seen = bus.iresp.data_ok;
            if (!seen) check({tag, ".wait_data"}, 64'(bus.iresp.data), 64'd0);
        end
        check({tag, ".latency"}, 64'(n), 64'(exp_lat));
        check({tag, ".data"}, 64'(bus.iresp.data), 64'(exp_data));
        check({tag, ".fault"}, 64'(fault), 64'(exp_fault));
        @(posedge clk); #1;
        ld_en = 1'b0;
        if (!hold) begin
            bus.ireq.valid = 1'b0;
            @(negedge clk);
            check({tag, ".idle_data_ok"}, 64'(bus.iresp.data_ok), 64'd0);
            check({tag, ".idle_data"}, 64'(bus.iresp.data), 64'd0);
            check({tag, ".idle_busy"}, 64'(busy), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t1, t2;
        bit  seen;
        bus.ireq = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.addr_ok", 64'(bus.iresp.addr_ok), 64'd0);
        check("rst.data_ok", 64'(bus.iresp.data_ok), 64'd0);
        check("rst.data",    64'(bus.iresp.data),    64'd0);
        check("rst.fault",   64'(fault),             64'd0);
        check("rst.busy",    64'(busy),              64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        load(12'd0, 64'h00A00513_00000013);
        load(12'd1, 64'h11112222_33334444);

        fetch("f_hi", 64'h8000_0004, 1'b0, MISS_LAT, 32'h00A00513, 1'b0, -1, '0, '0, t1);

        fetch("b2b0", 64'h8000_0000, 1'b1, HIT_LAT, 32'h00000013, 1'b0, -1, '0, '0, t1);
        fetch("b2b1", 64'h8000_0004, 1'b0, HIT_LAT, 32'h00A00513, 1'b0, -1, '0, '0, t2);
        check("b2b.gap", 64'(t2 - t1), 64'(HIT_LAT + 1));

        fetch("flt_mis", 64'h8000_0002, 1'b0, MISS_LAT, 32'h0, 1'b1, -1, '0, '0, t1);
        fetch("flt_low", 64'h7FFF_FFFC, 1'b0, MISS_LAT, 32'h0, 1'b1, -1, '0, '0, t1);
        fetch("flt_top", 64'h8000_8000, 1'b0, MISS_LAT, 32'h0, 1'b1, -1, '0, '0, t1);

        // Reset during the cycle after acceptance aborts the fetch.
        bus.ireq.valid = 1'b1;
        bus.ireq.addr  = 64'h8000_0008;
        @(negedge clk);
        check("abort.addr_ok", 64'(bus.iresp.addr_ok), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.ireq.valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort.busy",    64'(busy),              64'd0);
        check("abort.data_ok", 64'(bus.iresp.data_ok), 64'd0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.iresp.data_ok) seen = 1'b1;
        end
        check("abort.no_resp", 64'(seen), 64'd0);
        @(posedge clk); #1;

        fetch("post_rst", 64'h8000_0008, 1'b0, MISS_LAT, 32'h33334444, 1'b0, -1, '0, '0, t1);

        // A load to index 0 during the capture cycle: the old word is returned, the new one afterwards.
        fetch("coll", 64'h8000_0000, 1'b0, MISS_LAT, 32'h00000013, 1'b0, LATENCY, 12'd0,
              64'hDEADBEEF_CAFEF00D, t1);
        fetch("coll_new", 64'h8000_0000, 1'b0, MISS_LAT, 32'hCAFEF00D, 1'b0, -1, '0, '0, t1);

        fetch("rep", 64'h8000_0004, 1'b0, HIT_LAT, 32'hDEADBEEF, 1'b0, -1, '0, '0, t1);
        load(12'd0, 64'h01234567_89ABCDEF);
        fetch("inval", 64'h8000_0004, 1'b0, MISS_LAT, 32'h01234567, 1'b0, -1, '0, '0, t1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Responder end of the instruction bus. Accepts `ibus_req_t` fetch requests from the pipeline's fetch stage and answers with `ibus_resp_t` after a fixed number of wait states. It does this from an internal 64-bit-wide instruction memory that is preloaded through a load port. It serves as the instruction-side memory model for simulation and small FPGA builds, and replaces the external ibus-to-cbus path when the core is run standalone.

## Interface
Parameters:
- `DEPTH`, 4096: number of 64-bit memory words; power of two. `AW = $clog2(DEPTH)`.
- `LATENCY`, 2: wait-state cycles between acceptance and response; 0..15.
- `BASE`, 64'h8000_0000: byte address of word 0.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ireq`  in  `ibus_req_t`  fields `valid`, `addr` (u64).
- `iresp`  out  `ibus_resp_t`  fields `addr_ok`, `data_ok`, `data` (u32).
- `ld_en`  in  1  load-port write enable.
- `ld_addr`  in  AW  load-port word index.
- `ld_data`  in  64  load-port write data.
- `fault`  out  1  valid only with `data_ok`: request misaligned or out of range.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - `addr_ok` = `ireq.valid`, combinational.
  - On `valid`: latch `addr`, load wait counter with `LATENCY`, then go to WAIT. If `LATENCY`==0, go straight to RESP.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter reads 1, capture the memory word and fault flag into the response register, then go to RESP.
- RESP:
  - `data_ok`=1 for exactly one cycle.
  - `data` = addr[2] ? word[63:32] : word[31:0].
  - Next state is IDLE, unconditionally.
- Index = (addr − BASE) >> 3.
- Fault when either holds:
  - addr[1:0] != 0;
  - addr < BASE or addr ≥ BASE + 8·DEPTH (64-bit unsigned compare).
- On fault, `data` = 32'h0 and `fault`=1.
- Initiator rule: `valid` is held until `data_ok`. The RESP cycle never accepts; a request still pending is accepted in the following IDLE cycle.
- `valid` dropping mid-transaction is a protocol violation. The responder still completes, pulses `data_ok` and returns to IDLE.
- Only one request is outstanding at a time; `addr_ok` is 0 in WAIT and RESP.
- Load port:
  - Writes `ld_data` to `mem[ld_addr]` every cycle `ld_en`=1, in any state.
  - Same-cycle collision with the response capture is read-before-write: the old word is returned.
- Reset:
  - State goes to IDLE, counter and response register to 0.
  - Memory contents are preserved.
  - An in-flight request is dropped with no `data_ok`.

## Timing
- Reset values: `addr_ok`=0, `data_ok`=0, `data`=0, `fault`=0, `busy`=0.
- Accept at cycle T (`addr_ok`=1). `data_ok` at T+LATENCY+1.
- Throughput: one fetch per LATENCY+2 cycles.
- `data` and `fault` are driven from registers. `addr_ok` is combinational from state and `ireq.valid`.
- `data`/`fault` are 0 whenever `data_ok`=0.

## Configuration
- Macro `IMEM_LINEBUF_EN` enables a one-entry line buffer.
- Defined:
  - The buffer holds the last fetched 64-bit word, its index and a valid bit.
  - A non-faulting request whose index matches a valid entry goes IDLE→RESP and is served from the buffer: `data_ok` at T+1 regardless of `LATENCY`.
  - A miss fills the buffer at the WAIT→RESP capture.
  - The valid bit is cleared by `rst` and by any `ld_en` write whose `ld_addr` equals the buffered index, in the same cycle.
  - A hit in the same cycle as such an invalidating load reads memory instead: normal miss path.
- Undefined: there is no buffer, and every request takes LATENCY+1 cycles.

## Structure
- Package `common` gains:
  - `imem_state_t` enum (IDLE/WAIT/RESP);
  - `IMEM_BASE` constant (default for `BASE`);
  - `ibus_req_t`/`ibus_resp_t`, unchanged.
- Sub-module `imem_linebuf` (tag/data/valid register, hit compare, invalidate), instantiated only under `IMEM_LINEBUF_EN`.

## Test plan
- Preload `mem[0]`=64'h00A00513_00000013; `LATENCY`=2; request 0x8000_0004 → `addr_ok` at T, `data_ok` at T+3, `data`=32'h00A00513, `fault`=0.
- Back-to-back requests to 0x8000_0000 then 0x8000_0004 with `valid` held → `data_ok` at T+3 and T+7, data 32'h00000013 then 32'h00A00513.
- Fault cases, each giving `data_ok` at T+3, `fault`=1, `data`=0:
  - misaligned 0x8000_0002;
  - out-of-range 0x7FFF_FFFC;
  - out-of-range 0x8000_0000+8·DEPTH.
- `rst` asserted at T+1 of an accepted fetch → no `data_ok` and `busy`=0 next cycle; a subsequent fetch returns preserved memory data.
- Load-port collision: `ld_en` writing index 0 in the capture cycle of a fetch to 0x8000_0000 → old word returned; the next fetch returns the new word.
- `IMEM_LINEBUF_EN`:
  - repeat fetch of 0x8000_0004 → `data_ok` at T+1;
  - after `ld_en` to index 0, a fetch of 0x8000_0004 misses again, `data_ok` at T+3.
